// File: rtl/reg_wb_queue_pkg.sv
// Shared types for the write-back queue and the register file it feeds.
package reg_wb_queue_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    // One pending register write
    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;

    // Result of a bypass lookup
    typedef struct packed {
        logic                  hit;
        logic [REG_DATA_W-1:0] data;
    } byp_t;

endpackage

// File: rtl/wb_fifo.sv
// Pending-write FIFO: storage, wrapping pointers, count, and a per-slot valid
// vector so the parent can search every queued entry for bypass.
module wb_fifo
    import reg_wb_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  wb_entry_t             i_entry,
    input  logic                  i_pop,
    output wb_entry_t             o_head,
    output logic [CNT_W-1:0]      o_count,
    output logic [PTR_W-1:0]      o_rd_ptr,
    output logic [DEPTH-1:0]      o_valid,
    output wb_entry_t [DEPTH-1:0] o_mem
);

    wb_entry_t [DEPTH-1:0] r_mem;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [DEPTH-1:0]      r_valid;

    // Entry storage; contents are qualified by r_valid so it is never cleared
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_entry;
        end
    end

    // Pointers, count and valid bits; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
        end else begin
            if (i_pop) begin
                r_rd_ptr          <= r_rd_ptr + 1'b1;
                r_valid[r_rd_ptr] <= 1'b0;
            end
            if (i_push) begin
                r_wr_ptr          <= r_wr_ptr + 1'b1;
                r_valid[r_wr_ptr] <= 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head   = r_mem[r_rd_ptr];
    assign o_count  = r_count;
    assign o_rd_ptr = r_rd_ptr;
    assign o_valid  = r_valid;
    assign o_mem    = r_mem;

endmodule

// File: rtl/reg_wb_queue.sv
// Write-back queue in front of the register file. Results are buffered in a
// FIFO, drained one per cycle through a registered output stage, and every
// pending value is visible to the read ports through a combinational bypass.
module reg_wb_queue
    import reg_wb_queue_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter bit DISCARD_ZERO = 1'b1,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wb_valid,
    output logic                  wb_ready,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [REG_DATA_W-1:0] wb_data,
    output logic                  reg_wr,
    output logic [REG_ADDR_W-1:0] reg_write_addr,
    output logic [REG_DATA_W-1:0] reg_din,
    input  logic [REG_ADDR_W-1:0] reg_addr1,
    input  logic [REG_ADDR_W-1:0] reg_addr2,
    output logic                  byp_hit_1,
    output logic                  byp_hit_2,
    output logic [REG_DATA_W-1:0] byp_data_1,
    output logic [REG_DATA_W-1:0] byp_data_2,
    output logic [CNT_W-1:0]      occupancy
);

    wb_entry_t             w_in_entry;
    wb_entry_t             w_head;
    wb_entry_t [DEPTH-1:0] w_mem;
    logic [DEPTH-1:0]      w_valid;
    logic [PTR_W-1:0]      w_rd_ptr;
    logic [CNT_W-1:0]      w_count;
    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;
    byp_t                  w_byp1;
    byp_t                  w_byp2;

    logic                  r_reg_wr;
    wb_entry_t             r_out;

    // Ready looks only at the registered count so it never depends on wb_valid
    assign wb_ready   = (w_count < CNT_W'(DEPTH));
    assign w_accept   = wb_valid && wb_ready;
    // Writes to r0 finish the handshake but never enter the queue
    assign w_push     = w_accept && !(DISCARD_ZERO && (wb_addr == '0));
    // The register file never stalls, so the head drains every cycle it exists
    assign w_pop      = (w_count != '0);
    assign w_in_entry = '{addr: wb_addr, data: wb_data};

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_push   (w_push),
        .i_entry  (w_in_entry),
        .i_pop    (w_pop),
        .o_head   (w_head),
        .o_count  (w_count),
        .o_rd_ptr (w_rd_ptr),
        .o_valid  (w_valid),
        .o_mem    (w_mem)
    );

    // Output stage: one registered write strobe per popped entry; addr/data hold when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg_wr <= 1'b0;
            r_out    <= '0;
        end else begin
            r_reg_wr <= w_pop;
            if (w_pop) begin
                r_out <= w_head;
            end
        end
    end

    // Newest pending value for a read address. Walking oldest to youngest and
    // letting later matches overwrite gives the same answer as a youngest-first
    // search; the output stage is the oldest of all, so it is checked first.
    function automatic byp_t lookup(
        input logic [REG_ADDR_W-1:0] ra,
        input wb_entry_t [DEPTH-1:0] mem,
        input logic [DEPTH-1:0]      vld,
        input logic [PTR_W-1:0]      rd_ptr,
        input logic                  out_v,
        input wb_entry_t             out_e
    );
        byp_t             res;
        logic [PTR_W-1:0] idx;
        res = '0;
        if (out_v && (out_e.addr == ra)) begin
            res = '{hit: 1'b1, data: out_e.data};
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if (vld[idx] && (mem[idx].addr == ra)) begin
                res = '{hit: 1'b1, data: mem[idx].data};
            end
        end
        if (DISCARD_ZERO && (ra == '0)) begin
            res = '0;
        end
        return res;
    endfunction

    // Bypass search for both read ports
    always_comb begin
        w_byp1 = lookup(reg_addr1, w_mem, w_valid, w_rd_ptr, r_reg_wr, r_out);
        w_byp2 = lookup(reg_addr2, w_mem, w_valid, w_rd_ptr, r_reg_wr, r_out);
    end

    assign reg_wr         = r_reg_wr;
    assign reg_write_addr = r_out.addr;
    assign reg_din        = r_out.data;
    assign byp_hit_1      = w_byp1.hit;
    assign byp_data_1     = w_byp1.data;
    assign byp_hit_2      = w_byp2.hit;
    assign byp_data_2     = w_byp2.data;
    assign occupancy      = w_count;

endmodule
